// File: rtl/alu_shift_latch.sv
// Result latch and multi-cycle shift/rotate stage behind the cascaded ALU181 slices.
// Optional build macro SHIFT_ARITH_EN turns op 011 into an arithmetic shift right.
module alu_shift_latch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] F_in,
    input  logic             Cn4_n,
    input  logic [2:0]       op,
    input  logic [3:0]       count,
    input  logic             start,
    input  logic             bus_oe,
    output logic [WIDTH-1:0] Q,
    output logic             CY,
    output logic             ZF,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] bus_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_RCL  = 3'b100;
    localparam logic [2:0] OP_RCR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    // One shift/rotate step; the result is packed as {carry, value}.
    function automatic logic [WIDTH:0] shift_step(
        input logic [2:0]       sop,
        input logic [WIDTH-1:0] sq,
        input logic             scy
    );
        logic [WIDTH:0] res;
        case (sop)
            OP_SHL:  res = {sq[WIDTH-1], sq[WIDTH-2:0], 1'b0};
`ifdef SHIFT_ARITH_EN
            OP_SHR:  res = {sq[0], sq[WIDTH-1], sq[WIDTH-1:1]};
`else
            OP_SHR:  res = {sq[0], 1'b0, sq[WIDTH-1:1]};
`endif
            OP_RCL:  res = {sq[WIDTH-1], sq[WIDTH-2:0], scy};
            OP_RCR:  res = {sq[0], scy, sq[WIDTH-1:1]};
            OP_ROL:  res = {sq[WIDTH-1], sq[WIDTH-2:0], sq[WIDTH-1]};
            OP_ROR:  res = {sq[0], sq[0], sq[WIDTH-1:1]};
            default: res = {scy, sq};
        endcase
        return res;
    endfunction

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    logic [1:0]       state_r, state_s;
    logic [3:0]       remaining_r, remaining_s;
    logic [2:0]       op_r, op_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic             cy_r, cy_s;
    logic             zf_r, zf_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [2:0]       step_op_s;
    logic [WIDTH:0]   step_s;

    // Next-state, datapath and flag computation for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        op_s        = op_r;
        q_s         = q_r;
        cy_s        = cy_r;
        zf_s        = zf_r;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        // The first step uses the live op; later steps use the op latched at accept.
        if (state_r == ST_SHIFT) begin
            step_op_s = op_r;
        end else begin
            step_op_s = op;
        end
        step_s = shift_step(step_op_s, q_r, cy_r);

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_s = op;
                    if (op == OP_LOAD) begin
                        q_s         = F_in;
                        cy_s        = ~Cn4_n;
                        zf_s        = is_zero(F_in);
                        remaining_s = 4'd0;
                        state_s     = ST_DONE;
                        done_s      = 1'b1;
                    end else if ((op == OP_NOP) || (count == 4'd0)) begin
                        remaining_s = 4'd0;
                        state_s     = ST_DONE;
                        done_s      = 1'b1;
                    end else begin
                        q_s         = step_s[WIDTH-1:0];
                        cy_s        = step_s[WIDTH];
                        zf_s        = is_zero(step_s[WIDTH-1:0]);
                        remaining_s = count - 4'd1;
                        if (count == 4'd1) begin
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_SHIFT;
                            busy_s  = 1'b1;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                q_s         = step_s[WIDTH-1:0];
                cy_s        = step_s[WIDTH];
                zf_s        = is_zero(step_s[WIDTH-1:0]);
                remaining_s = remaining_r - 4'd1;
                if (remaining_r == 4'd1) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_SHIFT;
                    busy_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s     = ST_IDLE;
                remaining_s = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= 4'd0;
            op_r        <= OP_NOP;
            q_r         <= {WIDTH{1'b0}};
            cy_r        <= 1'b0;
            zf_r        <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            op_r        <= op_s;
            q_r         <= q_s;
            cy_r        <= cy_s;
            zf_r        <= zf_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign Q       = q_r;
    assign CY      = cy_r;
    assign ZF      = zf_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign bus_out = bus_oe ? q_r : {WIDTH{1'b0}};

endmodule

// File: doc/alu_shift_latch.md
Name: alu_shift_latch

Overview:
- Result stage directly downstream of the cascaded ALU181 slices in the model computer.
- Latches the ALU result F and its carry, then performs multi-cycle shift or rotate sequences on the latched value: logical, through-carry and circular.
- Maintains CY and ZF flags for the controller.
- Drives the latched result onto the internal data bus when enabled.

Parameters:
- WIDTH, 8, data width; equals 4 × the number of cascaded ALU181 slices.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- F_in  input  WIDTH  result from the most-significant…least-significant ALU slices.
- Cn4_n  input  1  active-low carry-out of the most significant ALU slice; CY captures ~Cn4_n.
- op  input  3  operation, sampled with start.
- count  input  4  shift step count, sampled with start.
- start  input  1  request; accepted only in IDLE.
- bus_oe  input  1  bus output enable.
- Q  output  WIDTH  latched/shifted result.
- CY  output  1  carry flag, active-high.
- ZF  output  1  zero flag.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.
- bus_out  output  WIDTH  combinational: bus_oe ? Q : 0.

Behaviour:
- Reset: when rst=1 at a clock edge, Q=0, CY=0, ZF=1, busy=0, done=0, state=IDLE, step counter=0. This applies in any state and aborts a shift in progress; no done pulse is generated.
- op encoding:
  - 000 NOP
  - 001 LOAD: Q←F_in, CY←~Cn4_n
  - 010 SHL: CY←Q[W-1], Q←{Q[W-2:0],0}
  - 011 SHR: CY←Q[0], Q←{0,Q[W-1:1]}
  - 100 RCL: {CY,Q}←{Q,CY}
  - 101 RCR: {Q,CY}←{CY,Q}
  - 110 ROL: Q←{Q[W-2:0],Q[W-1]}, CY←Q[W-1]
  - 111 ROR: Q←{Q[0],Q[W-1:1]}, CY←Q[0]
- States: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - op=000, 001, or any shift op with count=0: execute NOP/LOAD (shift with count=0 leaves Q and CY unchanged) on that edge, then go to DONE.
  - Shift op with count≥1: perform the first step on that edge, set remaining=count-1. Go to DONE if remaining=0, otherwise go to SHIFT.
- SHIFT: one step per edge; remaining decrements each step. When the decrement reaches 0, go to DONE. busy=1 throughout SHIFT.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE unconditionally.
- A shift of N completes in N edges; done is high in the cycle after the last step.
- start in SHIFT or DONE is ignored; the request is not queued.
- op, count and F_in are ignored outside the accepting edge. op and count are latched at accept.
- ZF is updated on every edge that writes Q: ZF=(new Q==0). It holds otherwise.
- CY changes only on LOAD or a shift step.
- NOP: Q and CY hold, ZF holds.
- Steps are modulo-free: count=15 performs 15 steps; a rotate of WIDTH steps restores Q.

Optional Feature:
- Macro SHIFT_ARITH_EN.
- Defined: op 011 is arithmetic shift right, Q←{Q[W-1],Q[W-1:1]}, CY←Q[0].
- Undefined: op 011 is logical SHR as specified above.
- All other ops are unaffected either way.

Test Plan:
- Reset mid-shift: load 0xFF, start ROL count=8, assert rst after 3 cycles → next edge Q=0x00, CY=0, ZF=1, busy=0; no done pulse.
- LOAD: F_in=0x96, Cn4_n=0, op=001, start → next edge Q=0x96, CY=1, ZF=0; done pulses one cycle later.
- SHL: from Q=0x96, op=010, count=3 → busy high for 2 cycles, final Q=0xB0, CY=0, done once.
- RCR: from Q=0x01, CY=0, op=101, count=1 → Q=0x00, CY=1, ZF=1. ROL count=8 from Q=0xA5 → Q=0xA5, CY=1.
- Ignored start: during an SHL count=5, pulse start with op=001, F_in=0x00 → ignored, and the final result equals the uninterrupted shift. Separately, a shift op with count=0 → Q and CY unchanged, done after 1 cycle.
- op 011, count=2 on Q=0x96 → with SHIFT_ARITH_EN: Q=0xE5, CY=1; without it: Q=0x25, CY=1. bus_oe=0 → bus_out=0x00; bus_oe=1 → bus_out=Q.
